// File: rtl/stream_mem_responder.sv
// Memory-side responder for the streaming read/write interface, backed by a local word array
// with a host preload/dump port. Optional address bounds checking: STREAM_RSP_BOUNDS_CHECK_EN.
module stream_mem_responder #(
    parameter int ADDR_WID   = 8,
    parameter int DATA_WID   = 32,
    parameter int WORD_SHIFT = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic [63:0]         read_size,
    input  logic                finish_read,
    output logic [63:0]         read_ready,
    output logic [DATA_WID-1:0] read_data,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [DATA_WID-1:0] write_data,
    input  logic                finish_write,
    output logic [63:0]         write_ready,
    input  logic                host_en,
    input  logic                host_we,
    input  logic [ADDR_WID-1:0] host_addr,
    input  logic [DATA_WID-1:0] host_wdata,
    output logic [DATA_WID-1:0] host_rdata,
    output logic                host_busy,
    output logic [31:0]         rd_beat_cnt,
    output logic [31:0]         wr_beat_cnt,
    output logic                err
);

    localparam int DEPTH = 1 << ADDR_WID;
    localparam int LAT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);
    localparam logic [DATA_WID-1:0] ERR_WORD = DATA_WID'(32'hDEADBEEF);

    typedef enum logic [1:0] {R_IDLE, R_LAT, R_VALID, R_ACK} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_VALID, W_ACK} wr_state_t;

    logic [DATA_WID-1:0] mem [DEPTH];

    rd_state_t           rd_state_q, rd_state_d;
    wr_state_t           wr_state_q, wr_state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [ADDR_WID-1:0] rd_idx_q, rd_idx_d;
    logic                rd_bad_q, rd_bad_d;
    logic [DATA_WID-1:0] rd_data_q;
    logic [DATA_WID-1:0] host_rdata_q;
    logic [31:0]         rd_cnt_q, wr_cnt_q;

    logic [ADDR_WID-1:0] rd_req_idx, wr_req_idx;
    logic                rd_req_bad, wr_req_bad;
    logic                rd_sample, rd_fetch, rd_fetch_bad;
    logic [ADDR_WID-1:0] rd_fetch_idx;
    logic                wr_commit;
    logic                host_ok, host_wr, host_rd;
    logic                mem_we;
    logic [ADDR_WID-1:0] mem_widx;
    logic [DATA_WID-1:0] mem_wdata;
    logic                unused_inputs;

    assign rd_req_idx = read_addr[WORD_SHIFT +: ADDR_WID];
    assign wr_req_idx = write_addr[WORD_SHIFT +: ADDR_WID];
    assign unused_inputs = ^{read_size, read_addr, write_addr};

`ifdef STREAM_RSP_BOUNDS_CHECK_EN
    // Address is bad if any bit above the word index or below the word boundary is set.
    function automatic logic addr_bad(input logic [63:0] a);
        logic [63:0] hi;
        logic [63:0] lo;
        hi = a >> (WORD_SHIFT + ADDR_WID);
        lo = a & ((64'd1 << WORD_SHIFT) - 64'd1);
        return (hi != 64'd0) || (lo != 64'd0);
    endfunction

    logic err_q;
    assign rd_req_bad = addr_bad(read_addr);
    assign wr_req_bad = addr_bad(write_addr);
    assign err        = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((rd_fetch && rd_fetch_bad) || (wr_commit && wr_req_bad)) begin
            err_q <= 1'b1;
        end
    end
`else
    assign rd_req_bad = 1'b0;
    assign wr_req_bad = 1'b0;
    assign err        = 1'b0;
`endif

    // Read FSM: a request is sampled from IDLE or from ACK on finish_read.
    always_comb begin
        rd_state_d   = rd_state_q;
        lat_cnt_d    = lat_cnt_q;
        rd_idx_d     = rd_idx_q;
        rd_bad_d     = rd_bad_q;
        rd_sample    = 1'b0;
        rd_fetch     = 1'b0;
        rd_fetch_idx = rd_req_idx;
        rd_fetch_bad = rd_req_bad;
        case (rd_state_q)
            R_IDLE:  rd_sample = read_enable;
            R_LAT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rd_state_d   = R_VALID;
                    rd_fetch     = 1'b1;
                    rd_fetch_idx = rd_idx_q;
                    rd_fetch_bad = rd_bad_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            R_VALID: rd_state_d = R_ACK;
            R_ACK: begin
                if (finish_read) begin
                    rd_sample = 1'b1;
                end else if (!read_enable) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        // With a single-cycle latency the array is read on the sampling edge itself.
        if (rd_sample) begin
            rd_idx_d  = rd_req_idx;
            rd_bad_d  = rd_req_bad;
            lat_cnt_d = '0;
            if (RD_LAT == 1) begin
                rd_state_d = R_VALID;
                rd_fetch   = 1'b1;
            end else begin
                rd_state_d = R_LAT;
            end
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_commit  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (write_enable) begin
                    wr_commit  = 1'b1;
                    wr_state_d = W_VALID;
                end
            end
            W_VALID: wr_state_d = W_ACK;
            W_ACK: begin
                if (finish_write) begin
                    wr_commit  = 1'b1;
                    wr_state_d = W_VALID;
                end else if (!write_enable) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign host_busy = (rd_state_q != R_IDLE) || (wr_state_q != W_IDLE);
    assign host_ok   = host_en && !host_busy;
    assign host_rd   = host_ok && !host_we;
    assign host_wr   = host_ok && host_we && !wr_commit;

    // Reset gates the write port so a beat presented during reset never lands.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = host_addr;
        mem_wdata = host_wdata;
        if (wr_commit && !wr_req_bad) begin
            mem_we    = !reset;
            mem_widx  = wr_req_idx;
            mem_wdata = write_data;
        end else if (host_wr) begin
            mem_we = !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q   <= R_IDLE;
            wr_state_q   <= W_IDLE;
            lat_cnt_q    <= '0;
            rd_idx_q     <= '0;
            rd_bad_q     <= 1'b0;
            rd_data_q    <= '0;
            host_rdata_q <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_idx_q   <= rd_idx_d;
            rd_bad_q   <= rd_bad_d;
            if (rd_fetch) begin
                rd_data_q <= rd_fetch_bad ? ERR_WORD : mem[rd_fetch_idx];
            end
            if (host_rd) begin
                host_rdata_q <= mem[host_addr];
            end
            if (rd_state_q == R_VALID) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_commit) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign read_ready  = {63'd0, rd_state_q == R_VALID};
    assign write_ready = {63'd0, wr_state_q == W_VALID};
    assign read_data   = rd_data_q;
    assign host_rdata  = host_rdata_q;
    assign rd_beat_cnt = rd_cnt_q;
    assign wr_beat_cnt = wr_cnt_q;

endmodule

// File: tb/tb_stream_mem_responder.sv
// Scoreboard bench for stream_mem_responder: stimulus pushes expected beats, a negedge monitor checks them.
module tb_stream_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable, finish_read, write_enable, finish_write;
    logic [63:0] read_addr, read_size, write_addr;
    logic [31:0] write_data;
    logic        host_en, host_we;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic [63:0] read_ready, write_ready;
    logic [31:0] read_data, host_rdata, rd_beat_cnt, wr_beat_cnt;
    logic        host_busy, err;

    logic        re3;
    logic [63:0] rr3, wrr3;
    logic [31:0] rd3, hr3, rc3, wc3;
    logic        hb3, err3;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_host_q[$];
    logic        rr_prev = 1'b0;
    logic        wr_prev = 1'b0;
    logic        host_pend = 1'b0;

    always #5 clk = ~clk;

    stream_mem_responder u_dut (
        .clk(clk), .reset(reset),
        .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
        .finish_read(finish_read), .read_ready(read_ready), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .finish_write(finish_write), .write_ready(write_ready),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_busy(host_busy),
        .rd_beat_cnt(rd_beat_cnt), .wr_beat_cnt(wr_beat_cnt), .err(err)
    );

    stream_mem_responder #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .read_enable(re3), .read_addr(64'd0), .read_size(64'd4),
        .finish_read(1'b0), .read_ready(rr3), .read_data(rd3),
        .write_enable(1'b0), .write_addr(64'd0), .write_data(32'd0),
        .finish_write(1'b0), .write_ready(wrr3),
        .host_en(1'b0), .host_we(1'b0), .host_addr(8'd0), .host_wdata(32'd0),
        .host_rdata(hr3), .host_busy(hb3),
        .rd_beat_cnt(rc3), .wr_beat_cnt(wc3), .err(err3)
    );

    always @(posedge clk) host_pend <= host_en && !host_we && !host_busy && !reset;

    // Monitor: every presented beat is popped from its queue and compared.
    always @(negedge clk) begin
        logic [31:0] e;
        if (read_ready != 64'd0) begin
            checks++;
            if (read_ready != 64'd1 || rr_prev) begin
                failures++;
                $display("FAIL rd_pulse read_ready=%h prev=%0d required single-cycle 1", read_ready, rr_prev);
            end
            checks++;
            if (exp_rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected read_data=%h required no beat", read_data);
            end else begin
                e = exp_rd_q.pop_front();
                if (read_data !== e) begin
                    failures++;
                    $display("FAIL rd_data got=%h exp=%h", read_data, e);
                end else $display("rd beat data=%h", read_data);
            end
        end
        if (write_ready != 64'd0) begin
            checks++;
            if (write_ready != 64'd1 || wr_prev) begin
                failures++;
                $display("FAIL wr_pulse write_ready=%h prev=%0d required single-cycle 1", write_ready, wr_prev);
            end
            checks++;
            if (exp_wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected wr_beat_cnt=%0d required no beat", wr_beat_cnt);
            end else begin
                e = exp_wr_q.pop_front();
                if (wr_beat_cnt !== e) begin
                    failures++;
                    $display("FAIL wr_cnt got=%0d exp=%0d", wr_beat_cnt, e);
                end else $display("wr beat cnt=%0d", wr_beat_cnt);
            end
        end
        if (host_pend) begin
            checks++;
            if (exp_host_q.size() == 0) begin
                failures++;
                $display("FAIL host_unexpected host_rdata=%h required no read", host_rdata);
            end else begin
                e = exp_host_q.pop_front();
                if (host_rdata !== e) begin
                    failures++;
                    $display("FAIL host_rdata got=%h exp=%h", host_rdata, e);
                end else $display("host read data=%h", host_rdata);
            end
        end
        rr_prev = read_ready[0];
        wr_prev = write_ready[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else $display("check %s = %h", name, got);
    endtask

    task automatic host_write(input logic [7:0] idx, input logic [31:0] d);
        host_en = 1'b1; host_we = 1'b1; host_addr = idx; host_wdata = d;
        tick();
        host_en = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] idx, input logic [31:0] exp);
        exp_host_q.push_back(exp);
        host_en = 1'b1; host_we = 1'b0; host_addr = idx;
        tick();
        host_en = 1'b0;
        tick();
    endtask

    task automatic wait_pulse(input logic is_rd, input string name);
        bit got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = is_rd ? read_ready[0] : write_ready[0];
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout ready=0 required pulse within 20 cycles", name);
        end
    endtask

    // abort_at > 0: assert reset right after that beat and check outputs cleared at once.
    task automatic rd_burst(input logic [63:0] base, input int n, input int abort_at);
        read_enable = 1'b1; read_addr = base;
        for (int b = 0; b < n; b++) begin
            wait_pulse(1'b1, "rd");
            if (abort_at != 0 && b + 1 == abort_at) begin
                #2 reset = 1'b1;
                #1;
                checks++;
                if ({read_ready, read_data, write_ready, host_rdata, host_busy,
                     rd_beat_cnt, wr_beat_cnt, err} != '0) begin
                    failures++;
                    $display("FAIL reset_mid rr=%h rd=%h wr=%h hr=%h busy=%0d rc=%0d wc=%0d err=%0d exp all 0",
                             read_ready, read_data, write_ready, host_rdata, host_busy,
                             rd_beat_cnt, wr_beat_cnt, err);
                end else $display("check reset_mid outputs cleared");
                read_enable = 1'b0;
                exp_rd_q.delete();
                tick();
                reset = 1'b0;
                return;
            end
            tick();
            if (b == n - 1) read_enable = 1'b0;
            else begin
                finish_read = 1'b1;
                read_addr = base + 64'(4 * (b + 1));
            end
            tick();
            finish_read = 1'b0;
        end
    endtask

    task automatic wr_burst(input logic [63:0] base, input logic [31:0] d0, input int n);
        write_enable = 1'b1; write_addr = base; write_data = d0;
        for (int b = 0; b < n; b++) begin
            wait_pulse(1'b0, "wr");
            tick();
            if (b == n - 1) write_enable = 1'b0;
            else begin
                finish_write = 1'b1;
                write_addr = base + 64'(4 * (b + 1));
                write_data = d0 + 32'(b + 1);
            end
            tick();
            finish_write = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        read_enable = 0; finish_read = 0; write_enable = 0; finish_write = 0;
        read_addr = 0; read_size = 64'd4; write_addr = 0; write_data = 0;
        host_en = 0; host_we = 0; host_addr = 0; host_wdata = 0; re3 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({read_ready, read_data, write_ready, host_rdata, host_busy,
             rd_beat_cnt, wr_beat_cnt, err, rr3} != '0) begin
            failures++;
            $display("FAIL reset_state rr=%h rd=%h wr=%h hr=%h busy=%0d rc=%0d wc=%0d err=%0d exp all 0",
                     read_ready, read_data, write_ready, host_rdata, host_busy,
                     rd_beat_cnt, wr_beat_cnt, err);
        end else $display("check reset_state outputs 0");
        reset = 1'b0;
        tick();

        // Preload and 8-beat read burst.
        for (int i = 0; i < 8; i++) host_write(8'(i), 32'(100 + i));
        for (int i = 0; i < 8; i++) exp_rd_q.push_back(32'(100 + i));
        rd_burst(64'd0, 8, 0);
        tick();
        check32("rd_beat_cnt_8", rd_beat_cnt, 32'd8);

        // Write burst at 0x40, dumped through the host port.
        for (int i = 1; i <= 4; i++) exp_wr_q.push_back(32'(i));
        wr_burst(64'h40, 32'hA0, 4);
        for (int i = 0; i < 4; i++) host_read(8'(16 + i), 32'hA0 + 32'(i));
        check32("wr_beat_cnt_4", wr_beat_cnt, 32'd4);

        // RD_LAT=3 instance: request cycle t -> read_ready only in t+3.
        re3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check32($sformatf("lat3_cycle%0d", k), {31'd0, rr3[0]}, (k == 3) ? 32'd1 : 32'd0);
        end
        tick();
        re3 = 1'b0;
        tick();

        // Reset after the third beat, then a full burst over intact data.
        for (int i = 0; i < 8; i++) exp_rd_q.push_back(32'(100 + i));
        rd_burst(64'd0, 8, 3);
        tick();
        for (int i = 0; i < 8; i++) exp_rd_q.push_back(32'(100 + i));
        rd_burst(64'd0, 8, 0);
        tick();
        check32("rd_beat_cnt_after_reset", rd_beat_cnt, 32'd8);

        // Out-of-range read address.
`ifdef STREAM_RSP_BOUNDS_CHECK_EN
        exp_rd_q.push_back(32'hDEADBEEF);
        rd_burst(64'h1_0000_0000, 1, 0);
        tick();
        check32("err_oob", {31'd0, err}, 32'd1);
`else
        exp_rd_q.push_back(32'd100);
        rd_burst(64'h1_0000_0000, 1, 0);
        tick();
        check32("err_oob", {31'd0, err}, 32'd0);
`endif

        // Same-edge read and write of idx5: read sees the old word.
        host_write(8'd5, 32'd7);
        exp_rd_q.push_back(32'd7);
        exp_wr_q.push_back(32'd1);
        read_enable = 1'b1; read_addr = 64'h14;
        write_enable = 1'b1; write_addr = 64'h14; write_data = 32'd9;
        @(negedge clk);
        @(negedge clk);
        check32("busy_in_burst", {31'd0, host_busy}, 32'd1);
        tick();
        read_enable = 1'b0; write_enable = 1'b0;
        tick();
        exp_rd_q.push_back(32'd9);
        rd_burst(64'h14, 1, 0);
        tick();
        host_read(8'd5, 32'd9);

        repeat (3) tick();
        check32("scoreboard_drain", 32'(exp_rd_q.size() + exp_wr_q.size() + exp_host_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
